instr_fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction decoder/controller in the single-issue MIPS datapath. Holds the program counter and issues word reads to instruction memory over a ready-based handshake. Presents the fetched instruction, with its PC, in a one-entry output register whose `opcode`/`funct` fields drive the controller's `OpCode`/`FuncCode` inputs. Folds unconditional `j` internally with zero bubbles, accepts taken-branch redirects from execute, and traps misaligned redirect targets.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/fetch_pc_gen.sv | 26 ++
 rtl/instr_fetch_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch FSM states and the
// jump-target formula reused by fetch and execute.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FAULT = 2'd2
    } fetch_state_e;

    // Pseudo-direct jump target: top nibble of pc+4, 26-bit index, word aligned.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [31:0] instr_word);
        return {pc_plus4[31:28], instr_word[25:0], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Combinational next-PC select: redirect target, folded j target, or pc+4.
module fetch_pc_gen
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_word_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] next_pc_o
);

    logic [31:0] pc_plus4;

    // Redirect wins over the fetched word; a j word folds into its target.
    always_comb begin
        pc_plus4 = pc_i + 32'd4;  // 32-bit modulo wrap is intended
        if (redirect_valid_i) begin
            next_pc_o = redirect_pc_i;
        end else if (instr_word_i[31:26] == OP_J) begin
            next_pc_o = jump_target(pc_plus4, instr_word_i);
        end else begin
            next_pc_o = pc_plus4;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC register, ready-based imem read, one-entry
// output register with stall back-pressure, redirect flush and alignment trap.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic        fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  instr_pc_q, instr_pc_d;
    logic         instr_valid_q, instr_valid_d;
    logic         fault_q, fault_d;
    logic [31:0]  next_pc;
    logic         accept;
    logic         misaligned;

    fetch_pc_gen u_pc_gen (
        .pc_i             (pc_q),
        .instr_word_i     (imem_rdata),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .next_pc_o        (next_pc)
    );

    // State register and output slot.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            fault_q       <= fault_d;
        end
    end

    // Next-state and request logic; redirect outranks accept and consume.
    always_comb begin
        // NOTE: hold-current defaults first, so no path can infer a latch.
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        fault_d       = fault_q;
        imem_req      = 1'b0;
        accept        = 1'b0;
        misaligned    = (redirect_pc[1:0] != 2'b00);

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = !instr_valid_q || !stall;
                accept   = imem_req && imem_ready && !redirect_valid;
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    if (misaligned) begin
                        state_d = FAULT;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc;
                    end
                end else if (accept) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc_q;
                    instr_valid_d = 1'b1;
                    pc_d          = next_pc;
                end else if (instr_valid_q && !stall) begin
                    instr_valid_d = 1'b0;
                end
            end
            default: begin
                // FAULT: inert until reset.
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign fault       = fault_q;

endmodule
